// File: rtl/nios_qsys_nios2_gen2_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : nios_qsys_nios2_gen2_cpu_div_cell
// Brief    : Sequential radix-2 restoring divider for div/divu, start/busy/done
// Revision : 1.0
// ============================================================================
module nios_qsys_nios2_gen2_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic             E_div_abort,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_src2;
    logic               r_signed;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;
    logic [WIDTH-1:0]   r_quot_out;
    logic [WIDTH-1:0]   r_rem_out;

    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_fire_done;

    assign w_neg1 = r_signed & r_src1[WIDTH-1];
    assign w_neg2 = r_signed & r_src2[WIDTH-1];
    assign w_mag1 = w_neg1 ? -r_src1 : r_src1;
    assign w_mag2 = w_neg2 ? -r_src2 : r_src2;

    // Extra top bit keeps the shifted-out MSB so the compare never loses a carry
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};

    assign w_fire_done = (r_state == S_FIX) && !E_div_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (E_div_start && !E_div_abort) w_state_nxt = S_PREP;
            S_PREP: w_state_nxt = E_div_abort ? S_IDLE : S_ITER;
            S_ITER: begin
                if (E_div_abort)              w_state_nxt = S_IDLE;
                else if (r_cnt == c_LAST_CNT) w_state_nxt = S_FIX;
            end
            S_FIX:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_signed   <= 1'b0;
            r_dvs      <= '0;
            r_dvd      <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_done     <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
        end else begin
            r_done <= w_fire_done;
            case (r_state)
                S_IDLE: begin
                    if (E_div_start && !E_div_abort) begin
                        r_src1   <= E_src1;
                        r_src2   <= E_src2;
                        r_signed <= E_div_signed;
                    end
                end
                S_PREP: begin
                    r_dvd   <= w_mag1;
                    r_dvs   <= w_mag2;
                    r_rem   <= '0;
                    r_neg_q <= w_neg1 ^ w_neg2;
                    r_neg_r <= w_neg1;
                    r_div0  <= (r_src2 == '0);
                    r_cnt   <= '0;
                end
                S_ITER: begin
                    // Dividend register fills with quotient bits from the bottom
                    r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
                    if (r_cnt != c_LAST_CNT) r_cnt <= r_cnt + c_CNT_W'(1);
                end
                S_FIX: begin
                    if (w_fire_done) begin
                        if (r_div0) begin
                            r_quot_out <= '1;
                            r_rem_out  <= r_src1;
                        end else begin
                            r_quot_out <= r_neg_q ? -r_dvd : r_dvd;
                            r_rem_out  <= r_neg_r ? -r_rem : r_rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign M_div_busy = (r_state != S_IDLE);
    assign M_div_done = r_done;
    assign M_div_quot = r_quot_out;
    assign M_div_rem  = r_rem_out;

endmodule
`default_nettype wire

// File: tb/tb_nios_qsys_nios2_gen2_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_qsys_nios2_gen2_cpu_div_cell
// Brief    : Directed self-checking bench for the sequential divider cell
// Revision : 1.0
// ============================================================================
module tb_nios_qsys_nios2_gen2_cpu_div_cell;

    logic        clk;
    logic        reset;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_div_start;
    logic        E_div_signed;
    logic        E_div_abort;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_quot;
    logic [31:0] M_div_rem;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;

    nios_qsys_nios2_gen2_cpu_div_cell #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .E_div_abort  (E_div_abort),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (M_div_busy && M_div_done) overlap++;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        E_src1       = a;
        E_src2       = b;
        E_div_signed = s;
        E_div_start  = 1'b1;
        tick();
        E_div_start  = 1'b0;
    endtask

    // Counts edges from the start edge until done is seen (bounded)
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = M_div_busy ? 1 : 0;
        while (!M_div_done && lat < 100) begin
            tick();
            lat++;
            if (M_div_busy) busy_n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
        int lat, bn;
        launch(a, b, s);
        wait_done(lat, bn);
        check({tag, "_lat"},  32'(lat), 32'd34);
        check({tag, "_quot"}, M_div_quot, eq);
        check({tag, "_rem"},  M_div_rem, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bn, dn, first_at;
        logic [31:0] q_first;

        reset        = 1'b1;
        E_src1       = '0;
        E_src2       = '0;
        E_div_start  = 1'b0;
        E_div_signed = 1'b0;
        E_div_abort  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(M_div_busy), 32'd0);
        check("rst_done", 32'(M_div_done), 32'd0);
        check("rst_quot", M_div_quot, 32'd0);
        check("rst_rem",  M_div_rem,  32'd0);
        reset = 1'b0;
        tick();

        // Unsigned 100/7 with busy-length check
        launch(32'd100, 32'd7, 1'b0);
        wait_done(lat, bn);
        check("divu_lat",  32'(lat), 32'd34);
        check("divu_busy", 32'(bn),  32'd34);
        check("divu_quot", M_div_quot, 32'h0000_000E);
        check("divu_rem",  M_div_rem,  32'h0000_0002);
        tick();
        check("done_pulse", 32'(M_div_done), 32'd0);

        run_op("sneg_pos", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("spos_neg", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001);
        run_op("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000);
        run_op("u_big",    32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h7FFF_FFFC, 32'h0000_0001);
        run_op("dz_u",     32'h1234_5678, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_op("dz_s",     32'h1234_5678, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        run_op("dz_sneg",  32'h8000_0005, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h8000_0005);

        // Back-to-back: start driven during the done cycle
        launch(32'd100, 32'd7, 1'b0);
        wait_done(lat, bn);
        check("b2b_first_quot", M_div_quot, 32'd14);
        run_op("b2b", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F);
        tick();

        // Second start while busy must be ignored
        launch(32'd100, 32'd7, 1'b0);
        for (int i = 1; i < 5; i++) tick();
        launch(32'd50, 32'd5, 1'b0);
        dn = 0;
        first_at = -1;
        q_first = '0;
        for (int i = 6; i < 90; i++) begin
            tick();
            if (M_div_done) begin
                dn++;
                if (first_at < 0) begin
                    first_at = i;
                    q_first  = M_div_quot;
                end
            end
        end
        check("ign_done_cnt", 32'(dn), 32'd1);
        check("ign_done_at",  32'(first_at), 32'd34);
        check("ign_quot",     q_first, 32'd14);
        check("ign_rem",      M_div_rem, 32'd2);

        // Abort at cycle 10 keeps prior results and emits no done
        launch(32'd1000, 32'd3, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        E_div_abort = 1'b1;
        tick();
        E_div_abort = 1'b0;
        check("abort_busy", 32'(M_div_busy), 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (M_div_done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_quot_hold", M_div_quot, 32'd14);
        check("abort_rem_hold",  M_div_rem,  32'd2);
        run_op("after_abort", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        tick();

        // Abort in IDLE suppresses a simultaneous start
        E_src1      = 32'd9;
        E_src2      = 32'd3;
        E_div_start = 1'b1;
        E_div_abort = 1'b1;
        tick();
        E_div_start = 1'b0;
        E_div_abort = 1'b0;
        check("idle_abort_busy", 32'(M_div_busy), 32'd0);

        // Abort landing on the FIX cycle
        launch(32'd9, 32'd3, 1'b0);
        for (int i = 1; i < 34; i++) tick();
        check("fix_busy_pre", 32'(M_div_busy), 32'd1);
        E_div_abort = 1'b1;
        tick();
        E_div_abort = 1'b0;
        check("fix_abort_done", 32'(M_div_done), 32'd0);
        check("fix_abort_busy", 32'(M_div_busy), 32'd0);
        check("fix_abort_quot", M_div_quot, 32'd333);
        tick();
        check("fix_abort_done2", 32'(M_div_done), 32'd0);

        // Reset mid-operation, then held with start asserted
        launch(32'd1000, 32'd3, 1'b0);
        for (int i = 1; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        check("mrst_busy", 32'(M_div_busy), 32'd0);
        check("mrst_done", 32'(M_div_done), 32'd0);
        check("mrst_quot", M_div_quot, 32'd0);
        check("mrst_rem",  M_div_rem,  32'd0);
        E_div_start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_start_busy", 32'(M_div_busy), 32'd0);
        reset       = 1'b0;
        E_div_start = 1'b0;
        tick();
        check("rst_release_busy", 32'(M_div_busy), 32'd0);

        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_qsys_nios2_gen2_cpu_div_cell.md
Name: nios_qsys_nios2_gen2_cpu_div_cell

Overview:
Sequential 32-bit integer divider for the Nios II gen2 CPU. It is the inverse-direction companion to the multiply cell and serves the div/divu instructions. It takes E-stage operands, iterates radix-2 restoring division one quotient bit per cycle, and returns the M-stage quotient and remainder with a start/busy/done handshake. The CPU stalls on M_div_busy and captures the result on M_div_done.

Parameters:
WIDTH, 32, operand/result width; iteration count = WIDTH; counter width = clog2(WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
E_src1  in  WIDTH  dividend
E_src2  in  WIDTH  divisor
E_div_start  in  1  start request, sampled only in IDLE
E_div_signed  in  1  1 = div (two's complement), 0 = divu
E_div_abort  in  1  pipeline flush; kills the operation in flight
M_div_busy  out  1  operation in progress
M_div_done  out  1  one-cycle pulse: results valid
M_div_quot  out  WIDTH  quotient, held until next done
M_div_rem  out  WIDTH  remainder, held until next done

Behaviour:
- Reset (synchronous, reset=1 at clock edge):
  - state=IDLE, counter=0.
  - M_div_busy=0, M_div_done=0, M_div_quot=0, M_div_rem=0.
  - Reset has priority over abort and start in all states, including mid-operation.
- IDLE:
  - On E_div_start=1 (and not abort): latch src1, src2 and signed; assert busy; go PREP.
  - Start asserted while busy is ignored (no queueing).
- PREP (1 cycle):
  - Compute magnitudes |src1| and |src2| when signed, else raw values.
  - Record neg_q = sign1 XOR sign2 and neg_r = sign1.
  - Flag div0 = (src2 == 0).
  - Clear partial remainder; counter=0; go ITER.
- ITER (exactly WIDTH cycles):
  - Shift {rem, dividend} left 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial and the quotient bit is 1; else the quotient bit is 0.
  - At counter = WIDTH-1, go FIX; otherwise increment counter.
- FIX (1 cycle):
  - If div0: M_div_quot = all ones and M_div_rem = the original src1, with no sign fixup, in both signed and unsigned mode.
  - Otherwise: quot = neg_q ? -q : q and rem = neg_r ? -r : r (truncating division; remainder takes the dividend's sign).
  - Register the outputs, pulse M_div_done=1, drop M_div_busy, go IDLE.
- Latency:
  - Start sampled at edge 0 gives done high during the cycle after edge WIDTH+2, i.e. 34 cycles for WIDTH=32.
  - Busy is high from edge 0 through edge WIDTH+1.
  - Done and busy are never high together.
- Back-to-back: a new start is accepted in the same cycle done is high, since state is IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF falls out of the magnitude path with no special case, giving quot=0x80000000 and rem=0.
- Abort:
  - E_div_abort=1 in PREP/ITER/FIX: go IDLE at the next edge, busy=0, no done pulse.
  - M_div_quot and M_div_rem keep their previous values.
  - Abort in IDLE suppresses a simultaneous start.
- Arithmetic: negation is two's complement mod 2^WIDTH; the ITER compare uses one extra bit so the carry is not lost.

Test Plan:
- Unsigned: divu 100/7 (signed=0) -> done exactly 34 cycles after start; quot=14 (0x0E), rem=2; busy high 34 cycles.
- Signed mixed sign: 0xFFFFFFF9 / 0x00000002 (signed=1) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Also 7 / -2 -> quot=0xFFFFFFFD, rem=1.
- Overflow and divide-by-zero:
  - 0x80000000 / 0xFFFFFFFF signed -> quot=0x80000000, rem=0.
  - 0x12345678 / 0 (both modes) -> quot=0xFFFFFFFF, rem=0x12345678.
- Handshake:
  - Second start pulsed at cycle 5 of a busy op -> ignored; only one done.
  - Start asserted in the done cycle with 0xFFFFFFFF/0x10 unsigned -> accepted; 34 cycles later quot=0x0FFFFFFF, rem=0xF.
- Abort: abort at cycle 10 of 1000/3 -> busy=0 next cycle, no done, outputs keep prior values. A following start of 1000/3 -> quot=333, rem=1.
- Reset mid-operation: reset=1 at cycle 20 of an op -> after the edge busy=0, done=0, quot=0, rem=0, state IDLE. Reset held with start=1 -> nothing accepted.
